// File: rtl/core_pkg.sv
// Shared types for the single-issue core: jump encodings from the decoder and
// the control-sequencer state encoding.
package core_pkg;

  localparam int unsigned Ilen = 32;

  typedef enum logic [1:0] {
    JumpNone = 2'd0,
    JumpJal  = 2'd1,
    JumpJalr = 2'd2
  } jump_type_e;

  typedef enum logic [2:0] {
    Fetch     = 3'd0,
    FetchWait = 3'd1,
    Execute   = 3'd2,
    MemReq    = 3'd3,
    MemWait   = 3'd4,
    Writeback = 3'd5,
    Trap      = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/core_pc_next.sv
// Combinational next-PC selection and control-flow target alignment check.
module core_pc_next
  import core_pkg::*;
#(
  parameter int unsigned Xlen = 32
) (
  input  logic [Xlen-1:0] pc,
  input  logic            branch,
  input  logic            branch_taken,
  input  jump_type_e      jump,
  input  logic [Xlen-1:0] target,
  output logic [Xlen-1:0] pc_plus4,
  output logic [Xlen-1:0] next_pc,
  output logic            misaligned
);

  assign pc_plus4 = pc + Xlen'(4);

  always_comb begin
    next_pc = pc_plus4;
    unique case (jump)
      JumpJal:  next_pc = target;
      JumpJalr: next_pc = {target[Xlen-1:1], 1'b0};
      default: begin
        if (branch && branch_taken) next_pc = target;
      end
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle sequencer: owns PC and IR, drives the instruction/data memory
// handshakes and pulses register-file writeback once per retired instruction.
module core_ctrl_fsm
  import core_pkg::*;
#(
  parameter int unsigned     Xlen    = 32,
  parameter logic [Xlen-1:0] ResetPc = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_valid_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [Xlen-1:0] imem_rdata_i,
  output logic            dmem_valid_o,
  input  logic            dmem_ready_i,
  input  logic            dmem_rvalid_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            branch_i,
  input  logic [1:0]      jump_i,
  input  logic            reg_wb_i,
  input  logic            branch_taken_i,
  input  logic [Xlen-1:0] target_i,
  output logic [Xlen-1:0] pc_o,
  output logic [Xlen-1:0] pc_plus4_o,
  output logic [Xlen-1:0] ir_o,
  output logic            rf_we_o,
  output logic            retire_o,
  output logic            trap_o
);

  ctrl_state_e     state_q, state_d;
  logic [Xlen-1:0] pc_q, ir_q, next_pc;
  logic            run_q;
  logic            ir_load, pc_load, misaligned;

  core_pc_next #(.Xlen(Xlen)) u_pc_next (
    .pc           (pc_q),
    .branch       (branch_i),
    .branch_taken (branch_taken_i),
    .jump         (jump_type_e'(jump_i)),
    .target       (target_i),
    .pc_plus4     (pc_plus4_o),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  // run_q keeps the fetch request low while reset is held and goes high on the
  // first edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Fetch;
      pc_q    <= ResetPc;
      ir_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      run_q   <= 1'b1;
      if (ir_load) ir_q <= imem_rdata_i;
      if (pc_load) pc_q <= next_pc;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d      = state_q;
    imem_valid_o = 1'b0;
    dmem_valid_o = 1'b0;
    rf_we_o      = 1'b0;
    retire_o     = 1'b0;
    trap_o       = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    unique case (state_q)
      Fetch: begin
        imem_valid_o = run_q;
        if (run_q && imem_ready_i) state_d = FetchWait;
      end
      FetchWait: begin
        if (imem_rvalid_i) begin
          ir_load = 1'b1;
          state_d = Execute;
        end
      end
      Execute: begin
        if (mem_read_i || mem_write_i) state_d = MemReq;
        else if (misaligned)           state_d = Trap;
        else                           state_d = Writeback;
      end
      MemReq: begin
        dmem_valid_o = 1'b1;
        if (dmem_ready_i) state_d = MemWait;
      end
      MemWait: begin
        if (dmem_rvalid_i) state_d = Writeback;
      end
      Writeback: begin
        rf_we_o  = reg_wb_i;
        retire_o = 1'b1;
        pc_load  = 1'b1;
        state_d  = Fetch;
      end
      Trap: begin
        trap_o = 1'b1;
      end
      default: state_d = Fetch;
    endcase
  end

  assign pc_o = pc_q;
  assign ir_o = ir_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Self-checking bench for core_ctrl_fsm: table of instructions served by a
// simple memory responder, a retire scoreboard, and hand sequences for reset and trap.
module tb_core_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid, imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_valid, dmem_ready, dmem_rvalid;
  logic        mem_read, mem_write, branch, reg_wb, branch_taken;
  logic [1:0]  jump;
  logic [31:0] target, pc, pc_plus4, ir;
  logic        rf_we, retire, trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_ctrl_fsm dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .imem_valid_o   (imem_valid),
    .imem_ready_i   (imem_ready),
    .imem_rvalid_i  (imem_rvalid),
    .imem_rdata_i   (imem_rdata),
    .dmem_valid_o   (dmem_valid),
    .dmem_ready_i   (dmem_ready),
    .dmem_rvalid_i  (dmem_rvalid),
    .mem_read_i     (mem_read),
    .mem_write_i    (mem_write),
    .branch_i       (branch),
    .jump_i         (jump),
    .reg_wb_i       (reg_wb),
    .branch_taken_i (branch_taken),
    .target_i       (target),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4),
    .ir_o           (ir),
    .rf_we_o        (rf_we),
    .retire_o       (retire),
    .trap_o         (trap)
  );

  typedef struct {
    logic [31:0] instr;
    logic        rd, wr, br, tk, wb;
    logic [1:0]  jmp;
    logic [31:0] tgt;
    int          ready_dly, iextra, dready_dly, dextra;
    logic [31:0] pc_before, pc_after;
    logic        we;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [31:0] pc_after;
    logic        we;
    int          cycles;
    logic [31:0] ir;
    logic [31:0] plus4;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic rd, input logic wr,
                              input logic br, input logic tk, input logic [1:0] jmp,
                              input logic wb, input logic [31:0] tgt, input int ready_dly,
                              input int iextra, input int dready_dly, input int dextra,
                              input logic [31:0] pc_before, input logic [31:0] pc_after,
                              input logic we, input int cycles);
    vec_t v;
    v.instr = instr; v.rd = rd; v.wr = wr; v.br = br; v.tk = tk; v.jmp = jmp; v.wb = wb;
    v.tgt = tgt; v.ready_dly = ready_dly; v.iextra = iextra; v.dready_dly = dready_dly;
    v.dextra = dextra; v.pc_before = pc_before; v.pc_after = pc_after; v.we = we;
    v.cycles = cycles;
    return v;
  endfunction

  task automatic clear_mem_inputs();
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // Runs one instruction, acting as both memories; called #1 after a posedge
  // while the DUT is (expected to be) in Fetch or just leaving reset.
  task automatic run_instr(input vec_t v, input string name);
    int   icnt = 0, dcnt = 0, iw = 0, dw = 0;
    bit   i_acc = 0, i_done = 0, d_acc = 0, d_done = 0, retired = 0;
    exp_t e;
    mem_read = v.rd; mem_write = v.wr; branch = v.br; branch_taken = v.tk;
    jump = v.jmp; reg_wb = v.wb; target = v.tgt;
    sb.push_back('{pc_after: v.pc_after, we: v.we, cycles: v.cycles,
                   ir: v.instr, plus4: v.pc_before + 32'd4});
    for (int cyc = 1; cyc <= 60 && !retired; cyc++) begin
      @(negedge clk);
      clear_mem_inputs();
      if (cyc == 1) begin
        check({name, "_fetch_valid"}, {31'd0, imem_valid}, 32'd1);
        check({name, "_pc_start"}, pc, v.pc_before);
      end
      if (retire) begin
        retired = 1;
        if (sb.size() == 0) begin
          check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({name, "_cycles"}, cyc, e.cycles);
          check({name, "_rf_we"}, {31'd0, rf_we}, {31'd0, e.we});
          check({name, "_ir"}, ir, e.ir);
          check({name, "_pc_plus4"}, pc_plus4, e.plus4);
        end
      end else begin
        if (rf_we) check({name, "_rf_we_early"}, {31'd0, rf_we}, 32'd0);
        if (imem_valid && !i_acc) begin
          if (icnt > 0) check({name, "_hold_pc"}, pc, v.pc_before);
          if (icnt == v.ready_dly) begin
            imem_ready = 1'b1;
            i_acc = 1;
          end else icnt++;
        end else if (i_acc && !i_done) begin
          iw++;
          if (iw == 1 + v.iextra) begin
            imem_rvalid = 1'b1;
            imem_rdata  = v.instr;
            i_done = 1;
          end
        end
        if (dmem_valid && !d_acc) begin
          if (dcnt == v.dready_dly) begin
            dmem_ready = 1'b1;
            d_acc = 1;
          end else dcnt++;
        end else if (d_acc && !d_done) begin
          dw++;
          if (dw == 1 + v.dextra) begin
            dmem_rvalid = 1'b1;
            d_done = 1;
          end
        end
      end
    end
    if (!retired) check({name, "_retire_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check({name, "_pc_after"}, pc, v.pc_after);
    check({name, "_retire_pulse"}, {31'd0, retire}, 32'd0);
  endtask

  initial begin
    vecs[0] = mk(32'h0010_0093, 0, 0, 0, 0, 2'd0, 1, 32'h0,         0, 0, 0, 0, 32'h00, 32'h04,  1, 4);
    vecs[1] = mk(32'h0020_8113, 0, 0, 0, 0, 2'd0, 1, 32'h0,         3, 0, 0, 0, 32'h04, 32'h08,  1, 7);
    vecs[2] = mk(32'h0000_a183, 1, 0, 0, 0, 2'd0, 1, 32'h0,         0, 0, 0, 2, 32'h08, 32'h0C,  1, 8);
    vecs[3] = mk(32'h0030_a023, 0, 1, 0, 0, 2'd0, 0, 32'h0,         0, 0, 1, 0, 32'h0C, 32'h10,  0, 7);
    vecs[4] = mk(32'h0210_8863, 0, 0, 1, 0, 2'd0, 0, 32'h40,        0, 0, 0, 0, 32'h10, 32'h14,  0, 4);
    vecs[5] = mk(32'h0210_8663, 0, 0, 1, 1, 2'd0, 0, 32'h40,        0, 0, 0, 0, 32'h14, 32'h40,  0, 4);
    vecs[6] = mk(32'h0400_00ef, 0, 0, 0, 0, 2'd1, 1, 32'h80,        0, 0, 0, 0, 32'h40, 32'h80,  1, 4);
    vecs[7] = mk(32'h0050_80e7, 0, 0, 0, 0, 2'd2, 1, 32'h105,       0, 1, 0, 0, 32'h80, 32'h104, 1, 5);

    clear_mem_inputs();
    mem_read = 0; mem_write = 0; branch = 0; branch_taken = 0; jump = 2'd0;
    reg_wb = 0; target = 32'h0;
    rst_n = 1'b0;
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_ir", ir, 32'h0);
    check("reset_outs", {26'd0, imem_valid, dmem_valid, rf_we, retire, trap, 1'b0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 8; i++) run_instr(vecs[i], $sformatf("vec%0d", i));

    // Load abandoned by a reset asserted while waiting for load data.
    mem_read = 1; mem_write = 0; branch = 0; branch_taken = 0; jump = 2'd0;
    reg_wb = 1; target = 32'h0;
    @(negedge clk); clear_mem_inputs();
    check("rst_seq_fetch", {31'd0, imem_valid}, 32'd1);
    imem_ready = 1'b1;
    @(negedge clk); clear_mem_inputs();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_a203;
    @(negedge clk); clear_mem_inputs();
    check("rst_seq_exec_no_dmem", {31'd0, dmem_valid}, 32'd0);
    @(negedge clk); clear_mem_inputs();
    check("rst_seq_dmem_valid", {31'd0, dmem_valid}, 32'd1);
    dmem_ready = 1'b1;
    @(negedge clk); clear_mem_inputs();
    check("rst_seq_memwait", {31'd0, dmem_valid}, 32'd0);
    @(negedge clk); clear_mem_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_ir", ir, 32'h0);
    check("midrst_outs", {26'd0, imem_valid, dmem_valid, rf_we, retire, trap, 1'b0}, 32'd0);
    dmem_rvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_mem_inputs();
    rst_n = 1'b1;
    #1;
    run_instr(mk(32'h0010_0093, 0, 0, 0, 0, 2'd0, 1, 32'h0, 0, 0, 0, 0,
                 32'h0, 32'h4, 1, 4), "post_rst_addi");

    // PC wrap-around from the top of the address space.
    run_instr(mk(32'hFF9F_F0EF, 0, 0, 0, 0, 2'd1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0,
                 32'h4, 32'hFFFF_FFFC, 1, 4), "jal_top");
    run_instr(mk(32'h0010_0093, 0, 0, 0, 0, 2'd0, 1, 32'h0, 0, 0, 0, 0,
                 32'hFFFF_FFFC, 32'h0, 1, 4), "wrap_addi");

    // Misaligned JAL target: sticky trap, no writeback, PC unchanged.
    mem_read = 0; mem_write = 0; branch = 0; branch_taken = 0; jump = 2'd1;
    reg_wb = 1; target = 32'h102;
    @(negedge clk); clear_mem_inputs();
    check("trap_fetch", {31'd0, imem_valid}, 32'd1);
    imem_ready = 1'b1;
    @(negedge clk); clear_mem_inputs();
    imem_rvalid = 1'b1; imem_rdata = 32'h1020_00EF;
    @(negedge clk); clear_mem_inputs();
    check("trap_exec_not_yet", {31'd0, trap}, 32'd0);
    @(negedge clk); clear_mem_inputs();
    check("trap_set", {29'd0, trap, retire, rf_we}, 32'd4);
    imem_ready = 1'b1; imem_rvalid = 1'b1; dmem_ready = 1'b1; dmem_rvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("trap_sticky%0d", i),
            {27'd0, trap, imem_valid, dmem_valid, retire, rf_we}, 32'h10);
      check($sformatf("trap_pc%0d", i), pc, 32'h0);
    end

    if (sb.size() != 0) check("sb_leftover", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
